// File: rtl/usb_rcv_ctrl.sv
// USB receive control FSM: tracks sync, data bytes and EOP, strobing FIFO writes.
// Latency: every output is registered or decoded from state, so it follows the input that caused it by one clk edge.
// Backpressure: none; the FIFO must accept a write on every w_enable pulse.
module usb_rcv_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       rcv_done,
  output logic [6:0] byte_count
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    BYTE_RCV,
    STORE,
    EOP_END,
    ERR_WAIT,
    ERR_EOP,
    ERR_IDLE
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] COUNT_MAX = 7'd127;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] byte_count_q, byte_count_d;
  logic       r_error_q, r_error_d;
  logic       rcv_done_q, rcv_done_d;
  logic       eop_s;

  // SE0 only matters when it is seen at a bit-sample instant.
  assign eop_s = eop & shift_enable;

  // Next-state logic; eop_s outranks byte_received so a byte that coincides with EOP is never stored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (d_edge) state_d = SYNC_RCV;
      SYNC_RCV: begin
        if (eop_s)              state_d = ERR_WAIT;
        else if (byte_received) state_d = SYNC_CHK;
      end
      SYNC_CHK: state_d = (rcv_data == SYNC_BYTE) ? BYTE_RCV : ERR_WAIT;
      BYTE_RCV: begin
        if (eop_s) begin
          if (bit_cnt_q == 3'd0 && byte_count_q != 7'd0) state_d = EOP_END;
          else                                           state_d = ERR_EOP;
        end else if (byte_received) begin
          state_d = STORE;
        end
      end
      STORE:    state_d = BYTE_RCV;
      EOP_END:  if (d_edge) state_d = IDLE;
      ERR_WAIT: if (eop_s) state_d = ERR_EOP;
      ERR_EOP:  if (d_edge) state_d = ERR_IDLE;
      ERR_IDLE: if (d_edge) state_d = SYNC_RCV;
      default:  state_d = IDLE;
    endcase
  end

  // Counters and sticky flags, all derived from the current/next state pair.
  always_comb begin
    byte_count_d = byte_count_q;
    bit_cnt_d    = bit_cnt_q;
    r_error_d    = r_error_q;
    rcv_done_d   = 1'b0;

    // A new packet (from IDLE or after an error) starts counting from zero.
    if (state_d == SYNC_RCV && state_q != SYNC_RCV) begin
      byte_count_d = 7'd0;
    end else if (state_q == STORE && byte_count_q != COUNT_MAX) begin
      byte_count_d = byte_count_q + 7'd1;
    end

    // Bit position within the current data byte, used to judge EOP alignment.
    if (state_d == BYTE_RCV && state_q != BYTE_RCV) begin
      bit_cnt_d = 3'd0;
    end else if (state_q == BYTE_RCV) begin
      if (byte_received)     bit_cnt_d = 3'd0;
      else if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // Error is raised entering either error state and only cleared by the restart edge.
    if (state_d == ERR_WAIT || state_d == ERR_EOP) begin
      r_error_d = 1'b1;
    end else if (state_q == ERR_IDLE && d_edge) begin
      r_error_d = 1'b0;
    end

    // Done is a single pulse covering the first EOP_END cycle.
    if (state_d == EOP_END && state_q != EOP_END) begin
      rcv_done_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      byte_count_q <= 7'd0;
      r_error_q    <= 1'b0;
      rcv_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_count_q <= byte_count_d;
      r_error_q    <= r_error_d;
      rcv_done_q   <= rcv_done_d;
    end
  end

  // Outputs come straight from state or registers, never from inputs.
  always_comb begin
    rcving     = (state_q == SYNC_RCV) || (state_q == SYNC_CHK) || (state_q == BYTE_RCV) ||
                 (state_q == STORE)    || (state_q == ERR_WAIT);
    w_enable   = (state_q == STORE);
    r_error    = r_error_q;
    rcv_done   = rcv_done_q;
    byte_count = byte_count_q;
  end

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed bench for usb_rcv_ctrl with a write/done scoreboard.
// Latency: inputs change 1 time unit after posedge; outputs sampled at negedge or #1 after posedge.
// Backpressure: not applicable; every w_enable must match a queued expected byte.
module tb_usb_rcv_ctrl;

  logic       clk;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic       rcv_done;
  logic [6:0] byte_count;

  int checks;
  int errors;
  int wr_seen;
  int done_seen;

  logic [7:0] exp_wr[$];
  logic [6:0] exp_done[$];

  usb_rcv_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_edge        (d_edge),
    .eop           (eop),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .rcv_data      (rcv_data),
    .rcving        (rcving),
    .w_enable      (w_enable),
    .r_error       (r_error),
    .rcv_done      (rcv_done),
    .byte_count    (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (w_enable === 1'b1) begin
        wr_seen++;
        checks++;
        assert (exp_wr.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed=%0h expected=none", rcv_data);
        end
        if (exp_wr.size() != 0) chk("write_data", rcv_data, exp_wr.pop_front());
      end
      if (rcv_done === 1'b1) begin
        done_seen++;
        checks++;
        assert (exp_done.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_done observed=%0h expected=none", byte_count);
        end
        if (exp_done.size() != 0) chk("done_count", byte_count, exp_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_pulse();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
  endtask

  task automatic send_bit(input logic eop_v);
    shift_enable = 1'b1;
    eop          = eop_v;
    tick();
    shift_enable = 1'b0;
    eop          = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (8) send_bit(1'b0);
    rcv_data      = b;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rcving"},     rcving,     1'b0);
    chk({tag, "_w_enable"},   w_enable,   1'b0);
    chk({tag, "_r_error"},    r_error,    1'b0);
    chk({tag, "_rcv_done"},   rcv_done,   1'b0);
    chk({tag, "_byte_count"}, byte_count, 7'd0);
  endtask

  initial begin
    checks = 0; errors = 0; wr_seen = 0; done_seen = 0;
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00;

    #12;
    chk_all_zero("reset");
    tick();
    n_rst = 1'b1;
    tick();

    // Good packet: sync, C3, 12, aligned EOP.
    exp_done.push_back(7'd2);
    edge_pulse();
    chk("good_rcving_start", rcving, 1'b1);
    send_byte(8'h80);
    exp_wr.push_back(8'hC3);
    exp_wr.push_back(8'h12);
    send_byte(8'hC3);
    send_byte(8'h12);
    send_bit(1'b1);
    chk("good_done_seen", done_seen, 1);
    chk("good_wr_seen", wr_seen, 2);
    chk("good_byte_count", byte_count, 7'd2);
    chk("good_r_error", r_error, 1'b0);
    chk("good_rcving_end", rcving, 1'b0);
    edge_pulse();
    chk("good_idle_rcving", rcving, 1'b0);

    // Bad sync byte.
    edge_pulse();
    send_byte(8'h81);
    chk("badsync_r_error", r_error, 1'b1);
    chk("badsync_rcving", rcving, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("badsync_wait_rcving", rcving, 1'b1);
    send_bit(1'b1);
    chk("badsync_eop_rcving", rcving, 1'b0);
    chk("badsync_eop_r_error", r_error, 1'b1);
    edge_pulse();
    chk("badsync_erridle_r_error", r_error, 1'b1);
    chk("badsync_erridle_rcving", rcving, 1'b0);
    edge_pulse();
    chk("badsync_restart_r_error", r_error, 1'b0);
    chk("badsync_restart_rcving", rcving, 1'b1);

    // Empty packet: EOP right after a valid sync.
    send_byte(8'h80);
    send_bit(1'b1);
    chk("empty_r_error", r_error, 1'b1);
    chk("empty_rcving", rcving, 1'b0);
    chk("empty_byte_count", byte_count, 7'd0);
    chk("empty_wr_seen", wr_seen, 2);
    edge_pulse();
    edge_pulse();

    // Early EOP at bit 5 of the second byte.
    send_byte(8'h80);
    exp_wr.push_back(8'h5A);
    send_byte(8'h5A);
    repeat (5) send_bit(1'b0);
    send_bit(1'b1);
    chk("early_r_error", r_error, 1'b1);
    chk("early_byte_count", byte_count, 7'd1);
    chk("early_done_seen", done_seen, 1);
    edge_pulse();
    edge_pulse();

    // byte_received coinciding with eop_s: EOP wins, nothing stored.
    send_byte(8'h80);
    exp_wr.push_back(8'hA5);
    send_byte(8'hA5);
    repeat (7) send_bit(1'b0);
    rcv_data = 8'h77; shift_enable = 1'b1; eop = 1'b1; byte_received = 1'b1;
    tick();
    shift_enable = 1'b0; eop = 1'b0; byte_received = 1'b0;
    tick();
    chk("simul_r_error", r_error, 1'b1);
    chk("simul_byte_count", byte_count, 7'd1);
    chk("simul_wr_seen", wr_seen, 4);
    edge_pulse();
    edge_pulse();

    // Reset in the middle of a packet.
    send_byte(8'h80);
    exp_wr.push_back(8'h11);
    send_byte(8'h11);
    repeat (3) send_bit(1'b0);
    chk("midrst_pre_rcving", rcving, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    n_rst = 1'b1;
    tick();

    // Clean packet after reset.
    exp_done.push_back(7'd3);
    edge_pulse();
    chk("post_rst_rcving", rcving, 1'b1);
    chk("post_rst_byte_count", byte_count, 7'd0);
    send_byte(8'h80);
    exp_wr.push_back(8'h01);
    exp_wr.push_back(8'h02);
    exp_wr.push_back(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_bit(1'b1);
    chk("post_rst_done_seen", done_seen, 2);
    chk("post_rst_byte_count_end", byte_count, 7'd3);
    edge_pulse();

    // Long packet: byte_count saturates; a stray d_edge mid-packet is ignored.
    exp_done.push_back(7'd127);
    edge_pulse();
    send_byte(8'h80);
    for (int i = 0; i < 128; i++) begin
      exp_wr.push_back(8'(i));
      send_byte(8'(i));
      if (i == 10) edge_pulse();
    end
    chk("sat_byte_count", byte_count, 7'd127);
    chk("sat_rcving", rcving, 1'b1);
    send_bit(1'b1);
    chk("sat_done_seen", done_seen, 3);
    chk("sat_r_error", r_error, 1'b0);
    chk("sat_wr_seen", wr_seen, 136);
    edge_pulse();

    chk("final_wr_queue_empty", exp_wr.size(), 0);
    chk("final_done_queue_empty", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rcv_ctrl.md
USB_RCV_CTRL -- requirements
Module: usb_rcv_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, n_rst.
REQ-002 Ports SHALL be as follows:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- d_edge  in  1  one-cycle pulse on a D+/D- transition
- eop  in  1  line currently in SE0
- shift_enable  in  1  one-cycle bit-sample strobe from the bit timer
- byte_received  in  1  one-cycle pulse, 8 unstuffed bits shifted
- rcv_data  in  8  current shift-register contents
- rcving  out  1  packet reception active; gates the bit timer
- w_enable  out  1  one-cycle write strobe to the receive FIFO
- r_error  out  1  sticky packet error flag
- rcv_done  out  1  one-cycle pulse on a good end of packet
- byte_count  out  7  bytes stored in the current packet

Function
REQ-003 eop_s SHALL be defined as eop & shift_enable (EOP sampled at a bit time).
REQ-004 The FSM SHALL have exactly these states: IDLE, SYNC_RCV, SYNC_CHK, BYTE_RCV, STORE, EOP_END, ERR_WAIT, ERR_EOP, ERR_IDLE. All transitions SHALL occur on the clk edge.
REQ-005 IDLE: on d_edge -> SYNC_RCV; byte_count cleared.
REQ-006 SYNC_RCV: eop_s -> ERR_WAIT; else byte_received -> SYNC_CHK.
REQ-007 SYNC_CHK (one cycle): rcv_data==8'h80 -> BYTE_RCV; otherwise -> ERR_WAIT.
REQ-008 BYTE_RCV transitions:
- byte_received & !eop_s -> STORE.
- eop_s with bit_cnt==0 and byte_count!=0 -> EOP_END.
- eop_s with bit_cnt!=0, or with byte_count==0 -> ERR_EOP.
REQ-009 bit_cnt (3-bit, internal) SHALL increment on each shift_enable in BYTE_RCV, clear on byte_received, and clear on entry to BYTE_RCV.
REQ-010 STORE (one cycle): w_enable=1; byte_count increments, saturating at 127; -> BYTE_RCV.
REQ-011 EOP_END: rcv_done=1 in the first cycle only; d_edge -> IDLE.
REQ-012 ERR_WAIT: eop_s -> ERR_EOP.
REQ-013 ERR_EOP: d_edge -> ERR_IDLE.
REQ-014 ERR_IDLE: d_edge -> SYNC_RCV; r_error clears on that same edge.
REQ-015 rcving SHALL be 1 in SYNC_RCV, SYNC_CHK, BYTE_RCV, STORE and ERR_WAIT, and 0 in all other states.
REQ-016 r_error SHALL be set on entry to ERR_WAIT or ERR_EOP. It SHALL stay 1 through ERR_IDLE and clear only per REQ-014 or on reset.
REQ-017 w_enable SHALL be asserted only in STORE; no write SHALL occur for the sync byte or after an error.
REQ-018 If byte_received and eop_s coincide, eop_s SHALL take priority (REQ-008 applies) and no STORE occurs.
REQ-019 A d_edge in any state other than those whose transitions reference d_edge SHALL be ignored.
REQ-020 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-021 On n_rst=0 the block SHALL asynchronously enter IDLE with rcving=0, w_enable=0, r_error=0, rcv_done=0, byte_count=0 and bit_cnt=0.
REQ-022 A reset asserted mid-packet SHALL abort the packet immediately, with no further w_enable or rcv_done.
REQ-023 After reset release, the first d_edge SHALL start reception.

Verification
REQ-024 Good packet: sync 8'h80, two bytes 8'hC3 and 8'h12, then eop_s at bit_cnt 0 -> two w_enable pulses, byte_count=2, one rcv_done, r_error=0, return to IDLE on d_edge.
REQ-025 Bad sync: rcv_data=8'h81 at the sync byte_received -> r_error=1 and rcving=1 until eop_s, then rcving=0; r_error=1 persists until the next d_edge after ERR_EOP and ERR_IDLE.
REQ-026 Early EOP: one byte stored, then eop_s at bit_cnt=5 -> r_error=1, no rcv_done, byte_count=1.
REQ-027 Empty packet: eop_s immediately after a valid sync -> ERR_EOP, r_error=1, zero w_enable pulses.
REQ-028 Simultaneous: byte_received and eop_s in the same cycle -> no w_enable, r_error=1.
REQ-029 Reset mid-packet: n_rst low during BYTE_RCV -> all outputs 0 asynchronously; the next packet is received cleanly with byte_count starting from 0.
